philosopher_ring: RTL and testbench

- Parametrised N-seat dining-philosopher ring: N philosopher cells with 2-bit state, neighbour wiring closed into a ring.
- Adds per-seat hunger-wait counters, a starvation flag, an optional fairness mode that lets starved seats go first, and a sticky safety monitor that flags adjacent eaters.
- Sits as a model-checking and benchmark design next to the single-philosopher cell; the verification flow uses the monitor output as a property.

---
 rtl/philosopher_ring.sv | 118 +++++++++++
 tb/tb_philosopher_ring.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/philosopher_ring.sv
// N-seat dining-philosopher ring with per-seat hunger counters, starvation flags,
// optional fairness arbitration and a sticky adjacent-eaters safety monitor.
module philosopher_ring #(
  parameter int unsigned N            = 5,
  parameter int unsigned CW           = 4,
  parameter int unsigned STARVE_LIMIT = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*N-1:0]           init,
  input  logic [N-1:0]             random,
  input  logic                     fair_en,
  output logic [2*N-1:0]           state_out,
  output logic [N-1:0]             starve,
  output logic [$clog2(N+1)-1:0]   eat_count,
  output logic                     violation
);

  localparam int unsigned EW = $clog2(N + 1);

  typedef enum logic [1:0] {
    StThinking = 2'd0,
    StReading  = 2'd1,
    StEating   = 2'd2,
    StHungry   = 2'd3
  } seat_e;

  localparam logic [CW-1:0] CntMax      = '1;
  localparam logic [CW-1:0] StarveLimit = CW'(STARVE_LIMIT);

  seat_e         state_q [N];
  seat_e         state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic          violation_q, violation_d;
  logic [N-1:0]  adj_eat;

  for (genvar i = 0; i < N; i++) begin : g_seat
    localparam int unsigned L = (i + N - 1) % N;
    localparam int unsigned R = (i + 1) % N;

    logic          eat_ok;
    logic          yield_turn;
    logic          relax_right;
    seat_e         nxt;
    logic [CW-1:0] cnt_nxt;

    assign starve[i]  = (state_q[i] == StHungry) && (cnt_q[i] >= StarveLimit);
    assign adj_eat[i] = (state_q[i] == StEating) && (state_q[R] == StEating);

    // Fork arbitration: a starved seat may ignore a hungry right neighbour, and a
    // non-starved seat backs off while either neighbour is starved.
    always_comb begin
      yield_turn  = fair_en && (starve[L] || starve[R]) && !starve[i];
      relax_right = fair_en && starve[i] && !starve[R];
      eat_ok      = (state_q[L] != StEating) && (state_q[R] != StEating) &&
                    (relax_right || (state_q[R] != StHungry)) && !yield_turn;
    end

    // Seat next-state and hunger counter (counter runs only across HUNGRY->HUNGRY).
    always_comb begin
      nxt = state_q[i];
      unique case (state_q[i])
        StReading:  nxt = (state_q[L] == StThinking) ? StThinking : StReading;
        StThinking: begin
          if (state_q[R] == StReading) nxt = StReading;
          else                         nxt = random[i] ? StThinking : StHungry;
        end
        StEating:   nxt = random[i] ? StThinking : StEating;
        StHungry:   nxt = eat_ok ? StEating : StHungry;
        default:    nxt = state_q[i];
      endcase

      cnt_nxt = '0;
      if (state_q[i] == StHungry && nxt == StHungry) begin
        cnt_nxt = (cnt_q[i] == CntMax) ? CntMax : cnt_q[i] + 1'b1;
      end
    end

    assign state_d[i] = nxt;
    assign cnt_d[i]   = cnt_nxt;
  end

  // Sticky monitor: any adjacent eating pair latches until reset.
  always_comb begin
    violation_d = violation_q | (|adj_eat);
  end

  // State, counter and monitor registers with synchronous reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= seat_e'(init[2*i +: 2]);
        cnt_q[i]   <= '0;
      end
      violation_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      violation_q <= violation_d;
    end
  end

  // Output packing and eater population count.
  always_comb begin
    state_out = '0;
    eat_count = '0;
    for (int i = 0; i < N; i++) begin
      state_out[2*i +: 2] = state_q[i];
      eat_count = eat_count + EW'(state_q[i] == StEating);
    end
  end

  assign violation = violation_q;

endmodule

// File: tb/tb_philosopher_ring.sv
// Bench for philosopher_ring: directed scenarios plus randomized traffic, all
// checked by a queue-based scoreboard against a behavioural ring model.
module tb_philosopher_ring;

  localparam int N            = 5;
  localparam int CW           = 4;
  localparam int STARVE_LIMIT = 10;
  localparam int EW           = $clog2(N + 1);
  localparam int CMAX         = (1 << CW) - 1;

  localparam int TH = 0, RD = 1, EA = 2, HU = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [2*N-1:0] init;
  logic [N-1:0]   random;
  logic           fair_en;
  logic [2*N-1:0] state_out;
  logic [N-1:0]   starve;
  logic [EW-1:0]  eat_count;
  logic           violation;

  philosopher_ring #(
    .N           (N),
    .CW          (CW),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .random   (random),
    .fair_en  (fair_en),
    .state_out(state_out),
    .starve   (starve),
    .eat_count(eat_count),
    .violation(violation)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*N-1:0] st;
    logic [N-1:0]   sv;
    logic [EW-1:0]  ec;
    logic           v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model state (value after the most recently driven edge).
  int m_st  [N];
  int m_cnt [N];
  bit m_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_starved(input int i);
    return (m_st[i] == HU) && (m_cnt[i] >= STARVE_LIMIT);
  endfunction

  task automatic model_step(input bit rst, input logic [2*N-1:0] ini,
                            input logic [N-1:0] rnd, input bit fair);
    int nx [N];
    int nc [N];
    bit sv [N];
    bit adj;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_st[i]  = int'(ini[2*i +: 2]);
        m_cnt[i] = 0;
      end
      m_v = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) sv[i] = m_starved(i);
    adj = 1'b0;
    for (int i = 0; i < N; i++) begin
      int  l, r;
      bit  ok;
      l = (i + N - 1) % N;
      r = (i + 1) % N;
      if (m_st[i] == EA && m_st[r] == EA) adj = 1'b1;
      case (m_st[i])
        TH: nx[i] = (m_st[r] == RD) ? RD : (rnd[i] ? TH : HU);
        RD: nx[i] = (m_st[l] == TH) ? TH : RD;
        EA: nx[i] = rnd[i] ? TH : EA;
        default: begin
          ok = (m_st[l] != EA) && (m_st[r] != EA);
          if (!(fair && sv[i] && !sv[r]) && m_st[r] == HU) ok = 1'b0;
          if (fair && (sv[l] || sv[r]) && !sv[i]) ok = 1'b0;
          nx[i] = ok ? EA : HU;
        end
      endcase
      if (m_st[i] == HU && nx[i] == HU) nc[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
      else                              nc[i] = 0;
    end
    for (int i = 0; i < N; i++) begin
      m_st[i]  = nx[i];
      m_cnt[i] = nc[i];
    end
    m_v = m_v | adj;
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    int   eaters;
    eaters = 0;
    for (int i = 0; i < N; i++) begin
      e.st[2*i +: 2] = 2'(m_st[i]);
      e.sv[i]        = m_starved(i);
      if (m_st[i] == EA) eaters++;
    end
    e.ec = EW'(eaters);
    e.v  = m_v;
    return e;
  endfunction

  function automatic logic [2*N-1:0] pk(input int s0, input int s1, input int s2,
                                        input int s3, input int s4);
    return {2'(s4), 2'(s3), 2'(s2), 2'(s1), 2'(s0)};
  endfunction

  // Drive one cycle of inputs and queue what the registers must hold after the edge.
  task automatic drive(input bit rst, input logic [2*N-1:0] ini,
                       input logic [N-1:0] rnd, input bit fair);
    @(negedge clk);
    reset   = rst;
    init    = ini;
    random  = rnd;
    fair_en = fair;
    model_step(rst, ini, rnd, fair);
    q.push_back(snapshot());
  endtask

  task automatic settle();
    @(posedge clk);
    #4;
  endtask

  // Scoreboard monitor: registered outputs are presented every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_state_out", 32'(state_out), 32'(e.st));
        chk("sb_starve",    32'(starve),    32'(e.sv));
        chk("sb_eat_count", 32'(eat_count), 32'(e.ec));
        chk("sb_violation", 32'(violation), 32'(e.v));
      end
    end
  end

  task automatic handoff(input bit fair);
    logic [N-1:0] rnd;
    bool_wait: begin end
    rnd = 5'b10100;  // p0 eats on, p2/p4 keep thinking, p3 eats on
    drive(1'b1, pk(EA, HU, TH, EA, TH), rnd, fair);
    for (int k = 0; k < 30; k++) begin
      drive(1'b0, '0, rnd, fair);
      settle();
      if (starve[1]) break;
    end
    chk(fair ? "fair_starve1_seen" : "unfair_starve1_seen", 32'(starve[1]), 32'd1);
    drive(1'b0, '0, 5'b10000, fair);  // p2 goes hungry
    drive(1'b0, '0, 5'b11001, fair);  // p0 and p3 stop eating
    drive(1'b0, '0, 5'b11001, fair);
    settle();
    if (fair) begin
      chk("fair_p1_eats",       32'(state_out[3:2]), 32'(EA));
      chk("fair_p2_waits",      32'(state_out[5:4]), 32'(HU));
      chk("fair_no_violation",  32'(violation),      32'd0);
    end else begin
      chk("unfair_p2_eats",     32'(state_out[5:4]), 32'(EA));
      chk("unfair_p1_hungry",   32'(state_out[3:2]), 32'(HU));
      drive(1'b0, '0, 5'b11001, fair);
      settle();
      chk("unfair_p1_still",    32'(state_out[3:2]), 32'(HU));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rnd;
    int unsigned  p;
    bit           fair;
    reset   = 1'b1;
    init    = '0;
    random  = '0;
    fair_en = 1'b0;

    // Reset load: p0..p4 = EATING, THINKING, READING, HUNGRY, EATING.
    drive(1'b1, pk(EA, TH, RD, HU, EA), '0, 1'b0);
    settle();
    chk("reset_state_out", 32'(state_out), 32'h2D2);
    chk("reset_starve",    32'(starve),    32'd0);
    chk("reset_violation", 32'(violation), 32'd0);
    chk("reset_eat_count", 32'(eat_count), 32'd2);

    // Deadlock: everyone hungry, nobody eats, starvation after ten hungry edges.
    drive(1'b1, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    settle();
    chk("deadlock_all_hungry", 32'(state_out), 32'h3FF);
    for (int k = 0; k < 9; k++) drive(1'b0, '0, '0, 1'b0);
    settle();
    chk("deadlock_no_starve_at_9", 32'(starve), 32'd0);
    drive(1'b0, '0, '0, 1'b0);
    settle();
    chk("deadlock_starve_at_10", 32'(starve), 32'h1F);
    for (int k = 0; k < 20; k++) drive(1'b0, '0, '0, 1'b0);
    settle();
    chk("deadlock_starve_saturated", 32'(starve),    32'h1F);
    chk("deadlock_eat_count",        32'(eat_count), 32'd0);

    // Safety monitor: adjacent eaters at reset release latch the flag.
    drive(1'b1, pk(EA, EA, TH, TH, TH), '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    settle();
    chk("monitor_set", 32'(violation), 32'd1);
    for (int k = 0; k < 3; k++) drive(1'b0, '0, '1, 1'b0);
    settle();
    chk("monitor_sticky", 32'(violation), 32'd1);
    drive(1'b1, '0, '1, 1'b0);
    settle();
    chk("monitor_cleared", 32'(violation), 32'd0);

    handoff(1'b1);
    handoff(1'b0);

    // READING chain: p1 releases, p0 reads for exactly one cycle.
    drive(1'b1, pk(TH, RD, TH, TH, TH), '1, 1'b0);
    drive(1'b0, '0, '1, 1'b0);
    settle();
    chk("chain_p0_reading", 32'(state_out[1:0]), 32'(RD));
    chk("chain_p1_thinking", 32'(state_out[3:2]), 32'(TH));
    drive(1'b0, '0, '1, 1'b0);
    settle();
    chk("chain_p0_back", 32'(state_out[1:0]), 32'(TH));

    // Randomized traffic with biased choice bits and occasional resets.
    drive(1'b1, 2*N'($urandom), '0, 1'b0);
    for (int seg = 0; seg < 40; seg++) begin
      p    = $urandom_range(0, 100);
      fair = 1'($urandom_range(0, 1));
      for (int c = 0; c < 20; c++) begin
        for (int i = 0; i < N; i++) rnd[i] = ($urandom_range(0, 99) < p);
        drive(($urandom_range(0, 39) == 0), 2*N'($urandom), rnd, fair);
      end
    end

    repeat (3) @(posedge clk);
    #4;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
